// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the register-file writeback path
//
// Purpose: widths, the hard-wired zero register number and the queue entry type
//          shared by rf_writeback and wb_queue.
// Contents: AW, DW, ZERO_REG, wb_entry_t {wr, wd}.
package rf_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - circular result queue with two pushes and one pop per edge
//
// Purpose: holds pending register-file writes in arrival order and exposes every
//          slot so the parent can search it for bypass matches.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push0/_entry  older push of this edge
//   i_push1/_entry  younger push of this edge
//   i_pop           remove the head entry
//   o_entries       raw contents of every slot
//   o_occ           per-slot occupancy
//   o_age           per-slot distance from head (larger = younger)
//   o_head          entry at the head pointer
//   o_count         number of occupied slots
module wb_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push0,
    input  wb_entry_t     i_push0_entry,
    input  logic          i_push1,
    input  wb_entry_t     i_push1_entry,
    input  logic          i_pop,
    output wb_entry_t     o_entries [DEPTH],
    output logic [DEPTH-1:0] o_occ,
    output logic [PW-1:0] o_age [DEPTH],
    output wb_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [1:0]    w_npush;
    logic [PW-1:0] w_slot1;

    assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
    // The younger push lands right behind the older one, or at the tail if alone.
    assign w_slot1 = i_push0 ? r_tail + PW'(1) : r_tail;

    always_ff @(posedge clk) begin
        if (i_push0) begin
            r_mem[r_tail] <= i_push0_entry;
        end
        if (i_push1) begin
            r_mem[w_slot1] <= i_push1_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_npush);
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_npush) - CW'(i_pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entries[i] = r_mem[i];
            o_age[i]     = PW'(i) - r_head;
            o_occ[i]     = {1'b0, o_age[i]} < r_count;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - ALU/load result collector driving the register-file write port
//
// Purpose: accepts results from the memory and ALU paths, queues them, retires one
//          per cycle to the register file and answers two bypass lookups.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_valid/wr/wd, mem_ready    memory-path result handshake (priority source)
//   alu_valid/wr/wd, alu_ready    ALU result handshake
//   regwr, wr, wd                 register-file write port
//   rr1/rr2, hit1/hit2, hd1/hd2   bypass lookups against pending writes
//   count                         occupied queue entries
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int DW    = rf_pkg::DW,
    parameter int AW    = rf_pkg::AW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_wr,
    input  logic [DW-1:0] mem_wd,
    output logic          mem_ready,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wr,
    input  logic [DW-1:0] alu_wd,
    output logic          alu_ready,
    output logic          regwr,
    output logic [AW-1:0] wr,
    output logic [DW-1:0] wd,
    input  logic [AW-1:0] rr1,
    input  logic [AW-1:0] rr2,
    output logic          hit1,
    output logic          hit2,
    output logic [DW-1:0] hd1,
    output logic [DW-1:0] hd2,
    output logic [CW-1:0] count
);

    import rf_pkg::*;

    wb_entry_t        w_entries [DEPTH];
    logic [DEPTH-1:0] w_occ;
    logic [PW-1:0]    w_age [DEPTH];
    wb_entry_t        w_head;
    logic [CW-1:0]    w_count;

    logic             w_nonempty;
    logic [CW-1:0]    w_free;
    logic             w_mem_acc;
    logic             w_alu_acc;
    logic             w_push0;
    logic             w_push1;
    wb_entry_t        w_mem_entry;
    wb_entry_t        w_alu_entry;

    logic             w_hit1;
    logic             w_hit2;
    logic [DW-1:0]    w_hd1;
    logic [DW-1:0]    w_hd2;
    logic [PW-1:0]    w_best1;
    logic [PW-1:0]    w_best2;

    // Nothing drains or matches while reset is held; the queue clears at the edge.
    assign w_nonempty = (w_count != '0) && !rst;

    // The head leaves on the same edge, so a non-empty queue has one extra slot.
    assign w_free = CW'(DEPTH) - w_count + CW'(w_nonempty);

    assign mem_ready = !rst && (w_free >= CW'(1));
    assign alu_ready = !rst && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !mem_valid));

    assign w_mem_acc = mem_valid && mem_ready;
    assign w_alu_acc = alu_valid && alu_ready;

    // Register 0 is hard-wired: the handshake completes but nothing is stored.
    assign w_push0 = w_mem_acc && (mem_wr != ZERO_REG);
    assign w_push1 = w_alu_acc && (alu_wr != ZERO_REG);

    assign w_mem_entry = '{wr: mem_wr, wd: mem_wd};
    assign w_alu_entry = '{wr: alu_wr, wd: alu_wd};

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .i_push0       (w_push0),
        .i_push0_entry (w_mem_entry),
        .i_push1       (w_push1),
        .i_push1_entry (w_alu_entry),
        .i_pop         (w_nonempty),
        .o_entries     (w_entries),
        .o_occ         (w_occ),
        .o_age         (w_age),
        .o_head        (w_head),
        .o_count       (w_count)
    );

    assign regwr = w_nonempty;
    assign wr    = w_nonempty ? w_head.wr : '0;
    assign wd    = w_nonempty ? w_head.wd : '0;
    assign count = w_count;

    // Youngest match wins so a register queued twice reads back its newer value.
    always_comb begin
        w_hit1  = 1'b0;
        w_hd1   = '0;
        w_best1 = '0;
        w_hit2  = 1'b0;
        w_hd2   = '0;
        w_best2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && w_occ[i] && (rr1 != ZERO_REG) && (w_entries[i].wr == rr1)
                && (!w_hit1 || (w_age[i] > w_best1))) begin
                w_hit1  = 1'b1;
                w_hd1   = w_entries[i].wd;
                w_best1 = w_age[i];
            end
            if (!rst && w_occ[i] && (rr2 != ZERO_REG) && (w_entries[i].wr == rr2)
                && (!w_hit2 || (w_age[i] > w_best2))) begin
                w_hit2  = 1'b1;
                w_hd2   = w_entries[i].wd;
                w_best2 = w_age[i];
            end
        end
    end

    assign hit1 = w_hit1;
    assign hit2 = w_hit2;
    assign hd1  = w_hd1;
    assign hd2  = w_hd2;

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed self-checking bench for rf_writeback
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_wr;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_wr;
    logic [31:0] alu_wd;
    logic        alu_ready;
    logic        regwr;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        hit1;
    logic        hit2;
    logic [31:0] hd1;
    logic [31:0] hd2;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_cnt [0:13] = '{0, 2, 3, 4, 4, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    logic [31:0] exp_wd  [0:13] = '{32'h0, 32'h1000, 32'h2000, 32'h1001, 32'h2001,
                                    32'h1002, 32'h2002, 32'h1003, 32'h1004, 32'h1005,
                                    32'h1006, 32'h1007, 32'h2003, 32'h0};
    logic [31:0] exp_ar  [0:8]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    rf_writeback #(
        .DEPTH (4),
        .DW    (32),
        .AW    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_wr    (mem_wr),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_wr    (alu_wr),
        .alu_wd    (alu_wd),
        .alu_ready (alu_ready),
        .regwr     (regwr),
        .wr        (wr),
        .wd        (wd),
        .rr1       (rr1),
        .rr2       (rr2),
        .hit1      (hit1),
        .hit2      (hit2),
        .hd1       (hd1),
        .hd2       (hd2),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_wr = '0; mem_wd = '0;
        alu_valid = 1'b0; alu_wr = '0; alu_wd = '0;
        rr1 = 5'd3; rr2 = 5'd0;

        tick();
        settle();
        chk("rst_mem_ready", 32'(mem_ready), 0);
        chk("rst_alu_ready", 32'(alu_ready), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_regwr", 32'(regwr), 0);
        chk("rst_wr", 32'(wr), 0);
        chk("rst_wd", wd, 0);
        chk("rst_hit1", 32'(hit1), 0);
        chk("rst_hd1", hd1, 0);
        rst = 1'b0;
        settle();
        chk("idle_mem_ready", 32'(mem_ready), 1);
        chk("idle_alu_ready", 32'(alu_ready), 1);
        tick();

        // single write
        alu_valid = 1'b1; alu_wr = 5'd3; alu_wd = 32'h0123;
        settle();
        chk("t1_alu_ready", 32'(alu_ready), 1);
        chk("t1_regwr_before", 32'(regwr), 0);
        tick();
        alu_valid = 1'b0;
        settle();
        chk("t1_regwr", 32'(regwr), 1);
        chk("t1_wr", 32'(wr), 3);
        chk("t1_wd", wd, 32'h0123);
        chk("t1_count", 32'(count), 1);
        chk("t1_hit1", 32'(hit1), 1);
        chk("t1_hd1", hd1, 32'h0123);
        tick();
        settle();
        chk("t1_regwr_after", 32'(regwr), 0);
        chk("t1_count_after", 32'(count), 0);
        chk("t1_hit1_after", 32'(hit1), 0);

        // dual accept, mem older than ALU
        mem_valid = 1'b1; mem_wr = 5'd2; mem_wd = 32'hAAAA;
        alu_valid = 1'b1; alu_wr = 5'd2; alu_wd = 32'hBBBB;
        rr1 = 5'd2;
        settle();
        chk("t2_mem_ready", 32'(mem_ready), 1);
        chk("t2_alu_ready", 32'(alu_ready), 1);
        chk("t2_hit1_not_yet", 32'(hit1), 0);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        settle();
        chk("t2_regwr0", 32'(regwr), 1);
        chk("t2_wr0", 32'(wr), 2);
        chk("t2_wd0", wd, 32'hAAAA);
        chk("t2_count0", 32'(count), 2);
        chk("t2_hit1_0", 32'(hit1), 1);
        chk("t2_hd1_0", hd1, 32'hBBBB);
        tick();
        settle();
        chk("t2_regwr1", 32'(regwr), 1);
        chk("t2_wd1", wd, 32'hBBBB);
        chk("t2_count1", 32'(count), 1);
        chk("t2_hd1_1", hd1, 32'hBBBB);
        tick();
        settle();
        chk("t2_regwr2", 32'(regwr), 0);
        chk("t2_hit1_2", 32'(hit1), 0);
        chk("t2_hd1_2", hd1, 0);

        // register 0 is discarded
        alu_valid = 1'b1; alu_wr = 5'd0; alu_wd = 32'hFFFF;
        rr1 = 5'd0;
        settle();
        chk("t3_alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        settle();
        chk("t3_count", 32'(count), 0);
        chk("t3_regwr", 32'(regwr), 0);
        chk("t3_hit1", 32'(hit1), 0);
        tick();
        settle();
        chk("t3_regwr_later", 32'(regwr), 0);

        // bypass returns youngest match
        mem_valid = 1'b1; mem_wr = 5'd5; mem_wd = 32'h1;
        alu_valid = 1'b1; alu_wr = 5'd5; alu_wd = 32'h2;
        tick();
        mem_valid = 1'b0;
        alu_wr = 5'd7; alu_wd = 32'h3;
        rr1 = 5'd5; rr2 = 5'd7;
        settle();
        chk("t5_alu_ready", 32'(alu_ready), 1);
        chk("t5_head_wd", wd, 32'h1);
        chk("t5_hd1_pre", hd1, 32'h2);
        chk("t5_hit2_pre", 32'(hit2), 0);
        tick();
        alu_valid = 1'b0;
        settle();
        chk("t5_count", 32'(count), 2);
        chk("t5_wr", 32'(wr), 5);
        chk("t5_wd", wd, 32'h2);
        chk("t5_hit1", 32'(hit1), 1);
        chk("t5_hd1", hd1, 32'h2);
        chk("t5_hit2", 32'(hit2), 1);
        chk("t5_hd2", hd2, 32'h3);
        tick();
        settle();
        chk("t5_wr_last", 32'(wr), 7);
        chk("t5_wd_last", wd, 32'h3);
        chk("t5_hit1_gone", 32'(hit1), 0);
        chk("t5_hd1_gone", hd1, 0);
        chk("t5_hit2_last", 32'(hit2), 1);
        chk("t5_hd2_last", hd2, 32'h3);
        tick();
        settle();
        chk("t5_hit1_end", 32'(hit1), 0);
        chk("t5_hit2_end", 32'(hit2), 0);
        chk("t5_hd2_end", hd2, 0);
        chk("t5_count_end", 32'(count), 0);

        // full queue with both sources pushing
        rr1 = 5'd0; rr2 = 5'd0;
        for (int k = 0; k < 14; k++) begin
            mem_valid = (k < 8);
            mem_wr    = 5'd8;
            mem_wd    = 32'h1000 + 32'(k);
            alu_valid = (k <= 8);
            alu_wr    = 5'd9;
            alu_wd    = 32'h2000 + 32'((k < 3) ? k : 3);
            settle();
            chk($sformatf("t4_count_c%0d", k), 32'(count), exp_cnt[k]);
            chk($sformatf("t4_regwr_c%0d", k), 32'(regwr), ((k >= 1) && (k <= 12)) ? 1 : 0);
            chk($sformatf("t4_wd_c%0d", k), wd, exp_wd[k]);
            if (k <= 8) begin
                chk($sformatf("t4_alu_ready_c%0d", k), 32'(alu_ready), exp_ar[k]);
            end
            if (k < 8) begin
                chk($sformatf("t4_mem_ready_c%0d", k), 32'(mem_ready), 1);
            end
            tick();
        end
        mem_valid = 1'b0; alu_valid = 1'b0;

        // reset with entries pending
        mem_valid = 1'b1; mem_wr = 5'd4;  mem_wd = 32'h44;
        alu_valid = 1'b1; alu_wr = 5'd6;  alu_wd = 32'h66;
        tick();
        mem_wr = 5'd12; mem_wd = 32'hCC;
        alu_wr = 5'd13; alu_wd = 32'hDD;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        settle();
        chk("t6_count_pre", 32'(count), 3);
        chk("t6_wd_pre", wd, 32'h66);
        rst = 1'b1;
        mem_valid = 1'b1; mem_wr = 5'd14; mem_wd = 32'hEE;
        alu_valid = 1'b1; alu_wr = 5'd15; alu_wd = 32'hFF;
        rr1 = 5'd6;
        settle();
        chk("t6_mem_ready_rst", 32'(mem_ready), 0);
        chk("t6_alu_ready_rst", 32'(alu_ready), 0);
        tick();
        rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
        settle();
        chk("t6_count_post", 32'(count), 0);
        chk("t6_regwr_post", 32'(regwr), 0);
        chk("t6_hit1_post", 32'(hit1), 0);
        tick();
        settle();
        chk("t6_regwr_later", 32'(regwr), 0);
        chk("t6_count_later", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side front end for the 32×32 register file: collects results from the ALU and memory (load) paths, queues them, and drives the register file's single write port (`regwr`/`wr`/`wd`) at one write per cycle. It sits between the execute/memory stages and the register file. Queued results are visible through two bypass lookup ports so the operand-read side (`rr1`/`rr2`) never sees a stale value.

## Interface
Parameters:
- `DEPTH`, 4: queue entries (power of two, ≥2).
- `DW`, 32: data width.
- `AW`, 5: register-number width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_valid` in 1: memory-path result offered.
- `mem_wr` in AW: memory-path destination register.
- `mem_wd` in DW: memory-path data.
- `mem_ready` out 1: memory-path result accepted this edge if `mem_valid`.
- `alu_valid` in 1: ALU result offered.
- `alu_wr` in AW: ALU destination register.
- `alu_wd` in DW: ALU data.
- `alu_ready` out 1: ALU result accepted this edge if `alu_valid`.
- `regwr` out 1: register-file write enable.
- `wr` out AW: register-file write address.
- `wd` out DW: register-file write data.
- `rr1`, `rr2` in AW: bypass lookup addresses, same values as the register-file read addresses.
- `hit1`, `hit2` out 1: a pending write to `rr1`/`rr2` exists.
- `hd1`, `hd2` out DW: youngest pending data for `rr1`/`rr2`.
- `count` out $clog2(DEPTH)+1: occupied entries.

## Operation
- Circular queue of {wr, wd} entries, with head pointer, tail pointer and count.
- Drain:
  - `regwr` = (count≠0).
  - `wr`/`wd` = head entry when count≠0, otherwise 0.
  - The head is popped on every edge where count≠0 and `rst`=0.
- Free slots: `free` = DEPTH − count + (count≠0), which credits the same-edge pop.
- Ready:
  - `mem_ready` = !rst && free≥1.
  - `alu_ready` = !rst && (free≥2 || (free≥1 && !mem_valid)).
  - The memory path has priority.
- Enqueue order on the same edge: the mem entry goes first (older), then the ALU entry. Up to two enqueues per edge.
- Writes to register 0:
  - The handshake completes normally, but the entry is discarded and never enqueued.
  - A discarded entry consumes no slot and does not change the ALU ready computation.
- Bypass:
  - `hitN` = (rrN≠0) and some occupied entry has wr==rrN. The head entry being written this cycle is included.
  - `hdN` = data of the youngest matching entry, or 0 if there is no hit.
  - Bypass is purely combinational.
  - Entries enqueued on the current edge are not visible until after that edge.
- Same register queued twice: both writes reach the register file in order, and the bypass returns the newer value.

## Timing
- Reset values: `regwr`=0, `wr`=0, `wd`=0, `count`=0, `hit1`/`hit2`=0, `hd1`/`hd2`=0, `mem_ready`/`alu_ready`=0 while `rst`=1.
- Reset mid-operation: all pending entries are lost. Handshakes offered during the reset cycle are not accepted.
- Latency: a result accepted at edge E drives `regwr`=1 during the cycle after E, and the register file is updated at edge E+1.
- Sustained rate: one register-file write per cycle. Single-source throughput is one result per cycle with no bubbles.
- Full (count=DEPTH): free=1 because of the same-edge pop.
  - A single source is accepted.
  - If both sources are valid, only mem is accepted and the ALU is stalled.
- Empty: `regwr`=0, no pop, no hits.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

## Structure
- Shared package `rf_pkg`:
  - `AW`, `DW`, `ZERO_REG` = 5'd0.
  - Entry struct `wb_entry_t` {wr, wd}.
- One natural sub-module, `wb_queue`:
  - Contains the storage, pointers and count, and supports 0–2 pushes and 0–1 pop per edge.
  - Exposes all entries plus per-entry occupancy and age, for the bypass search in the parent.
- The parent holds the ready logic, the zero-register filter and the two bypass comparators.

## Test plan
- Single write: after reset, ALU {wr=3, wd=0x0123} for one cycle -> the next cycle shows `regwr`=1, `wr`=3, `wd`=0x0123; the following cycle shows `regwr`=0.
- Dual accept with ordering: mem {2, 0xAAAA} and ALU {2, 0xBBBB} on the same edge -> two consecutive writes, 0xAAAA then 0xBBBB. With `rr1`=2 between the edges, `hd1` = 0xBBBB and `hit1`=1.
- Zero register: ALU {0, 0xFFFF} -> `alu_ready`=1 and `count` stays 0, so `regwr` is never asserted. With `rr1`=0, `hit1`=0.
- Full/backpressure: both sources valid every cycle for 8 cycles -> `count` saturates at DEPTH, the ALU is stalled while mem is accepted, the register-file writes stay in acceptance order, and none are lost or duplicated.
- Bypass youngest: queue {5, 1}, {5, 2}, {7, 3} -> `rr1`=5 gives hd1=2 and `rr2`=7 gives hd2=3. Once these drain, both hits are 0.
- Reset mid-operation: 3 entries queued, then `rst`=1 for one cycle -> `count`=0, `regwr`=0, both readys are 0 during reset, and no queued entries are written afterwards.
